// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I ALU-class decode and ID/EX issue register
// Optional one-entry skid buffer enabled with `define ALU_ISSUE_SKID_EN.

package alu_issue_pkg;
    typedef logic [31:0] data_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_t;

    typedef struct packed {
        alu_op_t     alu_op;
        data_t       data1;
        data_t       data2;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;
endpackage

module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  data_t       rs1_data_i,
    input  data_t       rs2_data_i,
    input  logic        flush_i,
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output alu_op_t     alu_op_o,
    output data_t       data1_o,
    output data_t       data2_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic [31:0] pc_o,
    output logic        illegal_o
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    function automatic alu_op_t f3_to_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    data_t      w_imm_i;
    data_t      w_imm_u;
    logic       w_legal;
    alu_op_t    w_op;
    data_t      w_d1;
    data_t      w_d2;
    entry_t     w_dec;
    logic       w_accept;
    logic       w_issue;

    entry_t     r_main;
    logic       r_main_valid;

    assign w_opcode   = instr_i[6:0];
    assign w_f3       = instr_i[14:12];
    assign w_f7       = instr_i[31:25];
    assign w_imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_u    = {instr_i[31:12], 12'b0};
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    always_comb begin
        w_legal = 1'b0;
        w_op    = ALU_ADD;
        w_d1    = '0;
        w_d2    = '0;
        case (w_opcode)
            OPC_OP: begin
                w_legal = 1'b1;
                w_d1    = rs1_data_i;
                w_d2    = rs2_data_i;
                if (w_f7 == F7_ZERO)
                    w_op = f3_to_op(w_f3);
                else if (w_f7 == F7_ALT && w_f3 == 3'b000)
                    w_op = ALU_SUB;
                else if (w_f7 == F7_ALT && w_f3 == 3'b101)
                    w_op = ALU_SRA;
                else
                    w_legal = 1'b0;
            end
            OPC_OPIMM: begin
                w_legal = 1'b1;
                w_d1    = rs1_data_i;
                w_d2    = w_imm_i;
                w_op    = f3_to_op(w_f3);
                // Shift-immediates reuse imm[11:5] as a funct7 qualifier.
                if (w_f3 == 3'b001 && w_f7 != F7_ZERO)
                    w_legal = 1'b0;
                if (w_f3 == 3'b101) begin
                    if (w_f7 == F7_ALT)
                        w_op = ALU_SRA;
                    else if (w_f7 != F7_ZERO)
                        w_legal = 1'b0;
                end
            end
            OPC_LUI: begin
                w_legal = 1'b1;
                w_op    = ALU_PASS;
                w_d2    = w_imm_u;
            end
            OPC_AUIPC: begin
                w_legal = 1'b1;
                w_d1    = pc_i;
                w_d2    = w_imm_u;
            end
            default: w_legal = 1'b0;
        endcase

        w_dec         = '0;
        w_dec.rd_addr = instr_i[11:7];
        w_dec.pc      = pc_i;
        w_dec.illegal = !w_legal;
        if (w_legal) begin
            w_dec.alu_op = w_op;
            w_dec.data1  = w_d1;
            w_dec.data2  = w_d2;
            w_dec.rd_we  = (instr_i[11:7] != 5'd0);
        end
    end

    assign w_accept = instr_valid_i && instr_ready_o;
    assign w_issue  = r_main_valid && ex_ready_i;

`ifdef ALU_ISSUE_SKID_EN
    entry_t r_skid;
    logic   r_skid_valid;
    logic   r_instr_ready;

    assign instr_ready_o = r_instr_ready;

    // Ready is low only while the skid holds an entry; main is then always full.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_main        <= '0;
            r_main.pc     <= RESET_PC;
            r_main_valid  <= 1'b0;
            r_skid        <= '0;
            r_skid_valid  <= 1'b0;
            r_instr_ready <= 1'b1;
        end else if (flush_i) begin
            r_main_valid  <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_instr_ready <= 1'b1;
        end else if (r_skid_valid) begin
            if (w_issue) begin
                r_main        <= r_skid;
                r_skid_valid  <= 1'b0;
                r_instr_ready <= 1'b1;
            end
        end else if (w_accept) begin
            if (!r_main_valid || w_issue) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else begin
                r_skid        <= w_dec;
                r_skid_valid  <= 1'b1;
                r_instr_ready <= 1'b0;
            end
        end else if (w_issue) begin
            r_main_valid <= 1'b0;
        end
    end
`else
    assign instr_ready_o = !r_main_valid || ex_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_main       <= '0;
            r_main.pc    <= RESET_PC;
            r_main_valid <= 1'b0;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main       <= w_dec;
            r_main_valid <= 1'b1;
        end else if (w_issue) begin
            r_main_valid <= 1'b0;
        end
    end
`endif

    assign ex_valid_o = r_main_valid;
    assign alu_op_o   = r_main.alu_op;
    assign data1_o    = r_main.data1;
    assign data2_o    = r_main.data2;
    assign rd_addr_o  = r_main.rd_addr;
    assign rd_we_o    = r_main.rd_we;
    assign pc_o       = r_main.pc;
    assign illegal_o  = r_main.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid_i, instr_ready_o;
    logic [31:0] instr_i, pc_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    data_t       rs1_data_i, rs2_data_i;
    logic        flush_i, ex_valid_o, ex_ready_i;
    alu_op_t     alu_op_o;
    data_t       data1_o, data2_o;
    logic [4:0]  rd_addr_o;
    logic        rd_we_o, illegal_o;
    logic [31:0] pc_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.RESET_PC(32'h0000_0040)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .pc_i(pc_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .alu_op_o(alu_op_o), .data1_o(data1_o), .data2_o(data2_o),
        .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .pc_o(pc_o), .illegal_o(illegal_o)
    );

    task automatic drive_one(input logic [31:0] ins, input logic [31:0] pc,
                             input logic [31:0] a, input logic [31:0] b);
        instr_i = ins; pc_i = pc; rs1_data_i = a; rs2_data_i = b;
        instr_valid_i = 1'b1; ex_ready_i = 1'b1;
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
    endtask

    task automatic drain();
        instr_valid_i = 1'b0; ex_ready_i = 1'b1; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid_i = 1'b0; ex_ready_i = 1'b0; flush_i = 1'b0;
        instr_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++; if (ex_valid_o !== 1'b0) $display("FAIL rst_ex_valid got %b want 0", ex_valid_o); else pass_cnt++;
        total_cnt++; if (illegal_o !== 1'b0) $display("FAIL rst_illegal got %b want 0", illegal_o); else pass_cnt++;
        total_cnt++; if (rd_we_o !== 1'b0) $display("FAIL rst_rd_we got %b want 0", rd_we_o); else pass_cnt++;
        total_cnt++; if (rd_addr_o !== 5'd0) $display("FAIL rst_rd_addr got %0d want 0", rd_addr_o); else pass_cnt++;
        total_cnt++; if (alu_op_o !== ALU_ADD) $display("FAIL rst_alu_op got %0d want %0d", alu_op_o, ALU_ADD); else pass_cnt++;
        total_cnt++; if (data1_o !== 32'd0) $display("FAIL rst_data1 got %h want 0", data1_o); else pass_cnt++;
        total_cnt++; if (data2_o !== 32'd0) $display("FAIL rst_data2 got %h want 0", data2_o); else pass_cnt++;
        total_cnt++; if (pc_o !== 32'h40) $display("FAIL rst_pc got %h want 00000040", pc_o); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (instr_ready_o !== 1'b1) $display("FAIL rst_ready got %b want 1", instr_ready_o); else pass_cnt++;
    endtask

    task automatic test_sub();
        instr_i = 32'h4020_8033;
        #1;
        total_cnt++; if (rs1_addr_o !== 5'd1) $display("FAIL rs1_addr got %0d want 1", rs1_addr_o); else pass_cnt++;
        total_cnt++; if (rs2_addr_o !== 5'd2) $display("FAIL rs2_addr got %0d want 2", rs2_addr_o); else pass_cnt++;
        drive_one(32'h4020_8033, 32'h0000_0010, 32'd10, 32'd3);
        total_cnt++; if (ex_valid_o !== 1'b1) $display("FAIL sub_valid got %b want 1", ex_valid_o); else pass_cnt++;
        total_cnt++; if (alu_op_o !== ALU_SUB) $display("FAIL sub_op got %0d want %0d", alu_op_o, ALU_SUB); else pass_cnt++;
        total_cnt++; if (data1_o !== 32'd10) $display("FAIL sub_data1 got %0d want 10", data1_o); else pass_cnt++;
        total_cnt++; if (data2_o !== 32'd3) $display("FAIL sub_data2 got %0d want 3", data2_o); else pass_cnt++;
        total_cnt++; if (rd_addr_o !== 5'd0) $display("FAIL sub_rd got %0d want 0", rd_addr_o); else pass_cnt++;
        total_cnt++; if (rd_we_o !== 1'b0) $display("FAIL sub_rd_we got %b want 0", rd_we_o); else pass_cnt++;
        total_cnt++; if (pc_o !== 32'h10) $display("FAIL sub_pc got %h want 00000010", pc_o); else pass_cnt++;
    endtask

    task automatic test_imm();
        drive_one(32'hFFF0_A093, 32'h0000_0014, 32'd7, 32'd99);
        total_cnt++; if (alu_op_o !== ALU_SLT) $display("FAIL slti_op got %0d want %0d", alu_op_o, ALU_SLT); else pass_cnt++;
        total_cnt++; if (data2_o !== 32'hFFFF_FFFF) $display("FAIL slti_data2 got %h want ffffffff", data2_o); else pass_cnt++;
        total_cnt++; if (rd_we_o !== 1'b1) $display("FAIL slti_rd_we got %b want 1", rd_we_o); else pass_cnt++;
        drive_one(32'h1234_5017, 32'h0000_0100, 32'd7, 32'd99);
        total_cnt++; if (alu_op_o !== ALU_ADD) $display("FAIL auipc_op got %0d want %0d", alu_op_o, ALU_ADD); else pass_cnt++;
        total_cnt++; if (data1_o !== 32'h100) $display("FAIL auipc_data1 got %h want 00000100", data1_o); else pass_cnt++;
        total_cnt++; if (data2_o !== 32'h1234_5000) $display("FAIL auipc_data2 got %h want 12345000", data2_o); else pass_cnt++;
        drive_one(32'h1234_50B7, 32'h0000_0104, 32'd7, 32'd99);
        total_cnt++; if (alu_op_o !== ALU_PASS) $display("FAIL lui_op got %0d want %0d", alu_op_o, ALU_PASS); else pass_cnt++;
        total_cnt++; if (data1_o !== 32'd0) $display("FAIL lui_data1 got %h want 0", data1_o); else pass_cnt++;
        total_cnt++; if (data2_o !== 32'h1234_5000) $display("FAIL lui_data2 got %h want 12345000", data2_o); else pass_cnt++;
        total_cnt++; if (rd_addr_o !== 5'd1) $display("FAIL lui_rd got %0d want 1", rd_addr_o); else pass_cnt++;
        drive_one(32'h4030_D093, 32'h0000_0108, 32'd7, 32'd99);
        total_cnt++; if (alu_op_o !== ALU_SRA) $display("FAIL srai_op got %0d want %0d", alu_op_o, ALU_SRA); else pass_cnt++;
        total_cnt++; if (data2_o !== 32'h403) $display("FAIL srai_data2 got %h want 00000403", data2_o); else pass_cnt++;
        total_cnt++; if (illegal_o !== 1'b0) $display("FAIL srai_illegal got %b want 0", illegal_o); else pass_cnt++;
    endtask

    task automatic test_illegal();
        drive_one(32'h0000_006F, 32'h0000_0200, 32'd5, 32'd6);
        total_cnt++; if (illegal_o !== 1'b1) $display("FAIL jal_illegal got %b want 1", illegal_o); else pass_cnt++;
        total_cnt++; if (rd_we_o !== 1'b0) $display("FAIL jal_rd_we got %b want 0", rd_we_o); else pass_cnt++;
        total_cnt++; if (alu_op_o !== ALU_ADD) $display("FAIL jal_op got %0d want %0d", alu_op_o, ALU_ADD); else pass_cnt++;
        drive_one(32'h0220_80B3, 32'h0000_0204, 32'd5, 32'd6);
        total_cnt++; if (illegal_o !== 1'b1) $display("FAIL mul_illegal got %b want 1", illegal_o); else pass_cnt++;
        total_cnt++; if (rd_we_o !== 1'b0) $display("FAIL mul_rd_we got %b want 0", rd_we_o); else pass_cnt++;
        total_cnt++; if (data1_o !== 32'd0) $display("FAIL mul_data1 got %h want 0", data1_o); else pass_cnt++;
        total_cnt++; if (data2_o !== 32'd0) $display("FAIL mul_data2 got %h want 0", data2_o); else pass_cnt++;
        drive_one(32'h4030_9093, 32'h0000_0208, 32'd5, 32'd6);
        total_cnt++; if (illegal_o !== 1'b1) $display("FAIL slli_alt_illegal got %b want 1", illegal_o); else pass_cnt++;
        total_cnt++; if (ex_valid_o !== 1'b1) $display("FAIL illegal_issues got %b want 1", ex_valid_o); else pass_cnt++;
    endtask

    task automatic test_stall_stream();
        logic [31:0] prog [4];
        logic [31:0] got [$];
        logic        rdy [8];
        logic        acc;
        int          idx = 0;
        logic        exp_c1, exp_c3;
        drain();
        for (int k = 0; k < 4; k++)
            prog[k] = (32'((k + 1) * 5) << 20) | (32'(k + 1) << 7) | 32'h13;
        rs1_data_i = '0;
        for (int c = 0; c < 20; c++) begin
            ex_ready_i    = (c >= 3);
            instr_valid_i = (idx < 4);
            if (idx < 4) instr_i = prog[idx];
            @(negedge clk);
            if (c < 8) rdy[c] = instr_ready_o;
            if (ex_valid_o && ex_ready_i) got.push_back(data2_o);
            acc = instr_valid_i && instr_ready_o;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        instr_valid_i = 1'b0;
`ifdef ALU_ISSUE_SKID_EN
        exp_c1 = 1'b1; exp_c3 = 1'b0;
`else
        exp_c1 = 1'b0; exp_c3 = 1'b1;
`endif
        total_cnt++; if (rdy[1] !== exp_c1) $display("FAIL stall_ready_c1 got %b want %b", rdy[1], exp_c1); else pass_cnt++;
        total_cnt++; if (rdy[2] !== 1'b0) $display("FAIL stall_ready_c2 got %b want 0", rdy[2]); else pass_cnt++;
        total_cnt++; if (rdy[3] !== exp_c3) $display("FAIL stall_ready_c3 got %b want %b", rdy[3], exp_c3); else pass_cnt++;
        total_cnt++; if (got.size() != 4) $display("FAIL stream_count got %0d want 4", got.size()); else pass_cnt++;
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            total_cnt++;
            if (got[k] !== 32'((k + 1) * 5)) $display("FAIL stream_order[%0d] got %0d want %0d", k, got[k], (k + 1) * 5);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        logic flush_rdy;
        logic exp_rdy;
        int   issued = 0;
        drain();
        rs1_data_i = '0; ex_ready_i = 1'b0;
        instr_i = 32'h0070_0293; instr_valid_i = 1'b1;
        @(posedge clk); #1;
        instr_i = 32'h0090_0313; flush_i = 1'b1;
        @(negedge clk);
        flush_rdy = instr_ready_o;
        @(posedge clk); #1;
        flush_i = 1'b0; instr_valid_i = 1'b0;
        total_cnt++; if (ex_valid_o !== 1'b0) $display("FAIL flush_valid got %b want 0", ex_valid_o); else pass_cnt++;
        total_cnt++; if (instr_ready_o !== 1'b1) $display("FAIL flush_ready_after got %b want 1", instr_ready_o); else pass_cnt++;
`ifdef ALU_ISSUE_SKID_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        total_cnt++; if (flush_rdy !== exp_rdy) $display("FAIL flush_ready_during got %b want %b", flush_rdy, exp_rdy); else pass_cnt++;
        ex_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ex_valid_o) issued++;
        end
        total_cnt++; if (issued != 0) $display("FAIL flush_no_issue got %0d want 0", issued); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drain();
        ex_ready_i = 1'b0; rs1_data_i = '0;
        instr_i = 32'h0010_0093; instr_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        instr_valid_i = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total_cnt++; if (ex_valid_o !== 1'b0) $display("FAIL midrst_valid got %b want 0", ex_valid_o); else pass_cnt++;
        total_cnt++; if (instr_ready_o !== 1'b1) $display("FAIL midrst_ready got %b want 1", instr_ready_o); else pass_cnt++;
        ex_ready_i = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (ex_valid_o !== 1'b0) $display("FAIL midrst_no_skid got %b want 0", ex_valid_o); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sub();
        test_imm();
        test_illegal();
        test_stall_stream();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage that sits upstream of the ALU in the 5-stage RV32I pipeline. It accepts fetched instructions over a valid/ready handshake and decodes the ALU-class opcodes (OP, OP-IMM, LUI, AUIPC) into `alu_op_t` plus operands. Operands come from the register file or are built from immediates and the PC. Results are held in the ID/EX pipeline register, which has its own valid/ready handshake toward execute. Stall, flush and illegal-instruction flagging are handled locally.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: value that `pc_o` takes at reset.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk_i`.
- `instr_valid_i`  in  1  fetch presents an instruction.
- `instr_ready_o`  out  1  stage accepts the instruction this cycle.
- `instr_i`  in  32  RV32I instruction word.
- `pc_i`  in  32  PC of `instr_i`.
- `rs1_addr_o`, `rs2_addr_o`  out  5 each  register file read addresses, taken combinationally from `instr_i[19:15]` and `instr_i[24:20]`.
- `rs1_data_i`, `rs2_data_i`  in  `data_t`  register file read data, returned in the same cycle.
- `flush_i`  in  1  discards the held entry and any instruction presented this cycle.
- `ex_valid_o`  out  1  ID/EX register holds a valid entry.
- `ex_ready_i`  in  1  execute consumes the entry this cycle.
- `alu_op_o`  out  `alu_op_t`  decoded ALU operation.
- `data1_o`, `data2_o`  out  `data_t`  ALU operands.
- `rd_addr_o`  out  5  destination register.
- `rd_we_o`  out  1  register write enable.
- `pc_o`  out  32  PC of the held entry.
- `illegal_o`  out  1  held entry is an unrecognised or non-ALU instruction.

## Operation
- Handshake:
  - Accept occurs when `instr_valid_i && instr_ready_o`.
  - Issue occurs when `ex_valid_o && ex_ready_i`.
  - Without the skid buffer, `instr_ready_o = !ex_valid_o || ex_ready_i`.
- Decode, by `instr_i[6:0]`:
  - OP (0110011): `data1 = rs1_data`, `data2 = rs2_data`. Mapping uses funct3 and funct7:
    - 000/0000000 → ADD; 000/0100000 → SUB
    - 001/0000000 → SLL; 010/0000000 → SLT; 011/0000000 → SLTU; 100/0000000 → XOR
    - 101/0000000 → SRL; 101/0100000 → SRA
    - 110/0000000 → OR; 111/0000000 → AND
    - Any other funct7 is illegal.
  - OP-IMM (0010011): `data1 = rs1_data`, `data2` = sign-extended `instr[31:20]`.
    - Same funct3 map as OP.
    - ADDI has no SUB variant.
    - SLLI requires `instr[31:25] = 0`. SRLI/SRAI require `instr[31:25]` = 0000000 or 0100000 respectively. Anything else is illegal.
  - LUI (0110111): PASS, `data1 = 0`, `data2 = {instr[31:12], 12'b0}`.
  - AUIPC (0010111): ADD, `data1 = pc_i`, `data2 = {instr[31:12], 12'b0}`.
  - Any other opcode is illegal.
- Illegal entry: `illegal_o = 1`, `alu_op_o = ADD`, `data1_o = data2_o = 0`, `rd_we_o = 0`. The entry still issues through the handshake.
- `rd_we_o = 0` whenever `rd = x0`.
- The ID/EX register loads on accept. On issue without a simultaneous accept, `ex_valid_o` clears.
- Payload outputs hold their values while `ex_valid_o = 1` and `ex_ready_i = 0`. Payload is don't-care when `ex_valid_o = 0`.

## Timing
- Latency: 1 cycle from accept to `ex_valid_o`. Throughput is 1 instruction per cycle when `ex_ready_i` stays high.
- Reset values: `ex_valid_o = 0`, `illegal_o = 0`, `rd_we_o = 0`, `rd_addr_o = 0`, `alu_op_o = ADD`, `data1_o = data2_o = 0`, `pc_o = RESET_PC`.
  - `instr_ready_o = 1` in the first cycle after reset.
  - Reset asserted mid-operation drops all held entries, including the skid entry.
- `flush_i` takes priority over accept:
  - Next cycle `ex_valid_o = 0` and the skid is empty.
  - An instruction presented in the flush cycle is dropped.
  - `instr_ready_o` is unaffected, so fetch sees the instruction as consumed.
- Simultaneous accept and issue: the new entry replaces the old one with no bubble.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - `instr_ready_o` is driven directly from a flop and has no combinational path from `ex_ready_i`.
  - A one-entry skid register captures an instruction accepted while the ID/EX register is stalled.
  - `instr_ready_o` is low exactly while the skid register is full.
  - When the main register issues, the skid entry moves into it, preserving order.
- `ALU_ISSUE_SKID_EN` undefined:
  - No skid register.
  - `instr_ready_o = !ex_valid_o || ex_ready_i`, combinationally.

## Test plan
- Reset with `rst_ni = 0` held 2 cycles → all outputs at the reset values above; `instr_ready_o = 1` in the first cycle after reset.
- Issue 0x40208033 (`sub x0,x1,x2`) with `rs1_data = 10`, `rs2_data = 3`, `ex_ready_i = 1` → next cycle SUB, `data1 = 10`, `data2 = 3`, `rd_addr = 0`, `rd_we = 0`.
- Issue 0xFFF0A093 (`slti x1,x1,-1`) → next cycle SLT, `data2 = 32'hFFFF_FFFF`, `rd_we = 1`. Issue 0x12345017 (`auipc x0`) at `pc_i = 0x100` → next cycle ADD, `data1 = 0x100`, `data2 = 0x12345000`.
- Stream 4 instructions with `ex_ready_i` low for 3 cycles, then high → in-order issue with no loss or duplication.
  - Skid on: `instr_ready_o` drops exactly 1 cycle after the first stalled accept.
  - Skid off: `instr_ready_o` is low throughout the stall.
- Issue 0x0000006F (JAL) → `illegal_o = 1`, `rd_we = 0`, `alu_op = ADD`.
- Assert `flush_i` while an entry is stalled and a new instruction is valid → next cycle `ex_valid_o = 0`, and neither instruction ever issues.
